mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single external memory port between the I-cache refill path and the D-cache MSHRs.
//  - Picks one requester per transaction using round-robin.
//  - Registers the winning request into a stable issue slot.
//  - Tags each outstanding read.
//  - Routes tagged, possibly out-of-order read responses back to the owning requester.
//  Sits between the cache miss handlers and the memory interface.
// PARAMETERS
//  REQ_NUM          3    requesters; index 0 = I-cache, 1..REQ_NUM-1 = D-cache MSHRs (1 + CONF_DCACHE_MSHR_NUM)
//  ADDR_WIDTH       32   physical address bits
//  LINE_WIDTH       256  line data bits (CONF_MEM_WIDTH*32)
//  MAX_OUTSTANDING  4    outstanding-read table entries; power of two, >=2
//  TAG_WIDTH        $clog2(MAX_OUTSTANDING)  memory tag bits
// PORTS
//  clk            in   1                    clock
//  rst            in   1                    synchronous, active-high reset
//  reqValid       in   REQ_NUM              per-requester request valid
//  reqIsWrite     in   REQ_NUM              1 = line write-back, 0 = line read
//  reqAddr        in   REQ_NUM*ADDR_WIDTH   line address (packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH])
//  reqData        in   REQ_NUM*LINE_WIDTH   write data (packed likewise)
//  reqAck         out  REQ_NUM              one-hot, 1-cycle pulse: request captured
//  memReqValid    out  1                    issue slot valid
//  memReqIsWrite  out  1                    issue slot kind
//  memReqAddr     out  ADDR_WIDTH           issue slot address
//  memReqData     out  LINE_WIDTH           issue slot write data
//  memReqTag      out  TAG_WIDTH            read tag; 0 for writes
//  memReqReady    in   1                    memory accepts issue slot this cycle
//  memRespValid   in   1                    read response valid
//  memRespTag     in   TAG_WIDTH            response tag
//  memRespData    in   LINE_WIDTH           response line
//  respValid      out  REQ_NUM              one-hot, 1-cycle: response for requester i
//  respData       out  LINE_WIDTH           response line
//  busy           out  1                    issue slot valid or any table entry valid
//  protocolError  out  1                    sticky: response with unallocated tag
// BEHAVIOUR
//  Reset
//  - All outputs 0; FSM = IDLE; rrPtr = 0; table cleared; protocolError cleared.
//  - Reset mid-transaction drops the issue slot and all outstanding entries; the memory side is reset together.
//  FSM
//  - IDLE -> ISSUE: some requester is eligible (defined below). The winner is latched into the memReq* registers and gets reqAck in the same cycle.
//  - ISSUE: memReqValid=1. memReq* are held stable until memReqReady=1.
//  - ISSUE -> IDLE: on the handshake cycle. rrPtr <= (winner+1) mod REQ_NUM.
//  - Throughput: at most one grant every 2 cycles.
//  Eligibility
//  - Requester i is eligible if reqValid[i] && (reqIsWrite[i] || a free table entry exists).
//  - Winner = first eligible index scanning rrPtr, rrPtr+1, ... with wrap.
//  - A read blocked by a full table is skipped; other requesters' writes still win.
//  Requester contract
//  - Hold reqValid/addr/data stable until reqAck.
//  - The cycle after reqAck, the requester may present a new request.
//  Table and tags
//  - Read grant reserves the lowest-index free entry. Entry index = memReqTag. The entry records the owner.
//  - Reservation happens at latch time, not at the handshake.
//  Responses
//  - memRespValid with a valid entry: next cycle respValid[owner]=1 and respData=memRespData (1-cycle registered latency). The entry frees at that same edge.
//  - Response to an invalid entry: no respValid; protocolError <= 1 (sticky until rst).
//  - A free and a grant in the same cycle: allocation sees pre-free state. The freed entry is usable from the next cycle.
//  - Responses may return in any tag order; each entry matches only its own tag.
// TESTING
//  1. Single read: req1 read @0x1000, ready=1 -> reqAck=3'b010; next cycle memReqValid, tag 0; resp tag0 -> respValid=3'b010 one cycle later.
//  2. All 3 reading at once, rrPtr=0 -> grant order 0,1,2, tags 0,1,2. Then new req0+req2 -> grant 0 then 2.
//  3. Backpressure: memReqReady low 5 cycles -> memReq* stable, no further reqAck. Ready=1 -> one handshake; IDLE next cycle.
//  4. Full table: 4 reads outstanding, req1 read + req2 write -> only req2 granted. Resp tag2 -> req1 granted with tag 2 the cycle after the free.
//  5. Out-of-order: tags 0..3 answered 3,1,0,2 -> respValid goes to the matching owners in that order. busy falls after the last.
//  6. Bogus tag 3 with empty table -> no respValid, protocolError=1 until rst. rst asserted while in ISSUE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares the single external memory port between the I-cache refill path
//   (requester 0) and the D-cache MSHRs (requesters 1..REQ_NUM-1). One
//   requester is picked per transaction in round-robin order and copied into a
//   stable issue slot. Each read is tagged with the index of an outstanding-read
//   table entry, so that tagged and possibly out-of-order read responses can be
//   routed back to the requester that owns them.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   reqValid         per-requester request valid
//   reqIsWrite       per-requester kind (1 = line write-back, 0 = line read)
//   reqAddr          packed line addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   reqData          packed write data, requester i at [i*LINE_WIDTH +: LINE_WIDTH]
//   reqAck           one-hot, single-cycle pulse: this cycle's request is captured
//   memReqValid      issue slot valid
//   memReqIsWrite    issue slot kind
//   memReqAddr       issue slot address
//   memReqData       issue slot write data
//   memReqTag        read tag (table entry index); 0 for writes
//   memReqReady      memory accepts the issue slot this cycle
//   memRespValid     read response valid
//   memRespTag       tag of the read response
//   memRespData      read response line
//   respValid        one-hot, single-cycle: response for requester i
//   respData         response line accompanying respValid
//   busy             issue slot valid or any table entry valid
//   protocolError    sticky: a response arrived for an unallocated tag
//
// REQ_NUM must be at least 2; MAX_OUTSTANDING is a power of two, at least 2.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int REQ_NUM         = 3,
   parameter int ADDR_WIDTH      = 32,
   parameter int LINE_WIDTH      = 256,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TAG_WIDTH       = $clog2(MAX_OUTSTANDING)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [REQ_NUM-1:0]            reqValid,
   input  logic [REQ_NUM-1:0]            reqIsWrite,
   input  logic [REQ_NUM*ADDR_WIDTH-1:0] reqAddr,
   input  logic [REQ_NUM*LINE_WIDTH-1:0] reqData,
   output logic [REQ_NUM-1:0]            reqAck,
   output logic                          memReqValid,
   output logic                          memReqIsWrite,
   output logic [ADDR_WIDTH-1:0]         memReqAddr,
   output logic [LINE_WIDTH-1:0]         memReqData,
   output logic [TAG_WIDTH-1:0]          memReqTag,
   input  logic                          memReqReady,
   input  logic                          memRespValid,
   input  logic [TAG_WIDTH-1:0]          memRespTag,
   input  logic [LINE_WIDTH-1:0]         memRespData,
   output logic [REQ_NUM-1:0]            respValid,
   output logic [LINE_WIDTH-1:0]         respData,
   output logic                          busy,
   output logic                          protocolError
);

   localparam int PTR_W = $clog2(REQ_NUM);

   typedef enum logic {
      ST_IDLE,
      ST_ISSUE
   } arbState_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   arbState_t               r_state;
   logic [PTR_W-1:0]        r_rrPtr;
   logic [PTR_W-1:0]        r_winner;
   logic                    r_memReqValid;
   logic                    r_memReqIsWrite;
   logic [ADDR_WIDTH-1:0]   r_memReqAddr;
   logic [LINE_WIDTH-1:0]   r_memReqData;
   logic [TAG_WIDTH-1:0]    r_memReqTag;

   logic [MAX_OUTSTANDING-1:0] r_entryValid;
   logic [PTR_W-1:0]           r_entryOwner [MAX_OUTSTANDING];
   logic [REQ_NUM-1:0]         r_respValid;
   logic [LINE_WIDTH-1:0]      r_respData;
   logic                       r_protocolError;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] w_addrArr [REQ_NUM];
   logic [LINE_WIDTH-1:0] w_dataArr [REQ_NUM];
   logic [REQ_NUM-1:0]    w_eligible;
   logic                  w_hasFree;
   logic [TAG_WIDTH-1:0]  w_freeIdx;
   logic                  w_found;
   logic [PTR_W-1:0]      w_winner;
   logic [REQ_NUM-1:0]    w_winnerOneHot;
   logic                  w_grant;
   logic                  w_grantRead;
   logic [PTR_W:0]        w_rrSum;
   logic [PTR_W-1:0]      w_rrNext;

   // Unpack the flat request buses so the winner can select by index.
   for (genvar g = 0; g < REQ_NUM; g++) begin : g_unpack
      assign w_addrArr[g] = reqAddr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_dataArr[g] = reqData[g*LINE_WIDTH +: LINE_WIDTH];
   end

   // Lowest-index free table entry. The scan runs from the top down so the
   // last hit, i.e. the lowest free index, is what remains. This looks only at
   // the registered table, so an entry freed by a response in the same cycle
   // is not offered until the following cycle.
   always_comb begin
      w_hasFree = 1'b0;
      w_freeIdx = '0;
      for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
         if (!r_entryValid[i]) begin
            w_hasFree = 1'b1;
            w_freeIdx = TAG_WIDTH'(i);
         end
      end
   end

   // Writes need no table entry, so a full table only holds back reads; other
   // requesters' writes can still win around a blocked read.
   assign w_eligible = reqValid & (reqIsWrite | {REQ_NUM{w_hasFree}});

   // Round-robin pick: first eligible requester starting at rrPtr, wrapping
   // around. The scan index is kept one bit wider so the wrap is a compare
   // and subtract rather than a general modulo.
   always_comb begin
      logic [PTR_W:0] scan;
      w_found  = 1'b0;
      w_winner = '0;
      scan     = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         scan = {1'b0, r_rrPtr} + (PTR_W+1)'(k);
         if (scan >= (PTR_W+1)'(REQ_NUM)) begin
            scan = scan - (PTR_W+1)'(REQ_NUM);
         end
         if (!w_found && w_eligible[scan[PTR_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = scan[PTR_W-1:0];
         end
      end
   end

   assign w_winnerOneHot = REQ_NUM'(1) << w_winner;

   // A grant only happens from IDLE, which limits the port to one grant every
   // two cycles. The acknowledge is combinational so the requester learns in
   // the capture cycle that it may present its next request afterwards.
   assign w_grant     = (r_state == ST_IDLE) && w_found && !rst;
   assign w_grantRead = w_grant && !reqIsWrite[w_winner];
   assign reqAck      = w_grant ? w_winnerOneHot : '0;

   // Pointer moves to the requester after the one just served.
   assign w_rrSum  = {1'b0, r_winner} + (PTR_W+1)'(1);
   assign w_rrNext = (w_rrSum >= (PTR_W+1)'(REQ_NUM)) ? '0 : w_rrSum[PTR_W-1:0];

   // ------------------------------------------------------------------------
   // Issue FSM: IDLE latches the winner into the issue slot; ISSUE holds the
   // slot stable until the memory takes it, then advances the round-robin
   // pointer past the winner.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_rrPtr         <= '0;
         r_winner        <= '0;
         r_memReqValid   <= 1'b0;
         r_memReqIsWrite <= 1'b0;
         r_memReqAddr    <= '0;
         r_memReqData    <= '0;
         r_memReqTag     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_state         <= ST_ISSUE;
                  r_winner        <= w_winner;
                  r_memReqValid   <= 1'b1;
                  r_memReqIsWrite <= reqIsWrite[w_winner];
                  r_memReqAddr    <= w_addrArr[w_winner];
                  r_memReqData    <= w_dataArr[w_winner];
                  r_memReqTag     <= reqIsWrite[w_winner] ? '0 : w_freeIdx;
               end
            end
            ST_ISSUE: begin
               if (memReqReady) begin
                  r_state       <= ST_IDLE;
                  r_memReqValid <= 1'b0;
                  r_rrPtr       <= w_rrNext;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outstanding-read table and response routing. A read reserves its entry
   // when it is latched, not at the memory handshake, so a response can never
   // find its tag missing. A matching response is forwarded one cycle later
   // and frees the entry on the same edge. A grant and a free in one cycle
   // always touch different entries, since the grant only picks an entry that
   // was already free. A response for an unallocated tag is dropped and
   // raises the sticky error flag.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_entryValid    <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            r_entryOwner[i] <= '0;
         end
         r_respValid     <= '0;
         r_respData      <= '0;
         r_protocolError <= 1'b0;
      end else begin
         r_respValid <= '0;
         if (memRespValid) begin
            if (r_entryValid[memRespTag]) begin
               r_respValid              <= REQ_NUM'(1) << r_entryOwner[memRespTag];
               r_respData               <= memRespData;
               r_entryValid[memRespTag] <= 1'b0;
            end else begin
               r_protocolError <= 1'b1;
            end
         end
         if (w_grantRead) begin
            r_entryValid[w_freeIdx] <= 1'b1;
            r_entryOwner[w_freeIdx] <= w_winner;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output wiring
   // ------------------------------------------------------------------------
   assign memReqValid   = r_memReqValid;
   assign memReqIsWrite = r_memReqIsWrite;
   assign memReqAddr    = r_memReqAddr;
   assign memReqData    = r_memReqData;
   assign memReqTag     = r_memReqTag;
   assign respValid     = r_respValid;
   assign respData      = r_respData;
   assign protocolError = r_protocolError;
   assign busy          = r_memReqValid | (|r_entryValid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Inputs are driven right after the
// falling edge, and outputs are sampled 1 time unit later, away from the
// rising edge. Each scenario task drives its own vectors and compares the
// outputs against hand-derived values.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int REQ_NUM         = 3;
   localparam int ADDR_WIDTH      = 32;
   localparam int LINE_WIDTH      = 256;
   localparam int MAX_OUTSTANDING = 4;
   localparam int TAG_WIDTH       = 2;

   logic                          clk = 1'b0;
   logic                          rst;
   logic [REQ_NUM-1:0]            reqValid;
   logic [REQ_NUM-1:0]            reqIsWrite;
   logic [REQ_NUM*ADDR_WIDTH-1:0] reqAddr;
   logic [REQ_NUM*LINE_WIDTH-1:0] reqData;
   logic [REQ_NUM-1:0]            reqAck;
   logic                          memReqValid;
   logic                          memReqIsWrite;
   logic [ADDR_WIDTH-1:0]         memReqAddr;
   logic [LINE_WIDTH-1:0]         memReqData;
   logic [TAG_WIDTH-1:0]          memReqTag;
   logic                          memReqReady;
   logic                          memRespValid;
   logic [TAG_WIDTH-1:0]          memRespTag;
   logic [LINE_WIDTH-1:0]         memRespData;
   logic [REQ_NUM-1:0]            respValid;
   logic [LINE_WIDTH-1:0]         respData;
   logic                          busy;
   logic                          protocolError;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .REQ_NUM         (REQ_NUM),
      .ADDR_WIDTH      (ADDR_WIDTH),
      .LINE_WIDTH      (LINE_WIDTH),
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .TAG_WIDTH       (TAG_WIDTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .reqValid      (reqValid),
      .reqIsWrite    (reqIsWrite),
      .reqAddr       (reqAddr),
      .reqData       (reqData),
      .reqAck        (reqAck),
      .memReqValid   (memReqValid),
      .memReqIsWrite (memReqIsWrite),
      .memReqAddr    (memReqAddr),
      .memReqData    (memReqData),
      .memReqTag     (memReqTag),
      .memReqReady   (memReqReady),
      .memRespValid  (memRespValid),
      .memRespTag    (memRespTag),
      .memRespData   (memRespData),
      .respValid     (respValid),
      .respData      (respData),
      .busy          (busy),
      .protocolError (protocolError)
   );

   // Advance to the next falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   // Drive one requester's request fields.
   task automatic applyStimulus(input int idx, input logic valid, input logic isWrite,
                                input logic [ADDR_WIDTH-1:0] addr, input logic [LINE_WIDTH-1:0] data);
      reqValid[idx]                          = valid;
      reqIsWrite[idx]                        = isWrite;
      reqAddr[idx*ADDR_WIDTH +: ADDR_WIDTH]  = addr;
      reqData[idx*LINE_WIDTH +: LINE_WIDTH]  = data;
   endtask

   // Drive the memory response channel.
   task automatic sendResp(input logic valid, input logic [TAG_WIDTH-1:0] tag,
                           input logic [LINE_WIDTH-1:0] data);
      memRespValid = valid;
      memRespTag   = tag;
      memRespData  = data;
   endtask

   // Hold reset for two rising edges with all inputs quiet.
   task automatic doReset();
      tick();
      rst         = 1'b1;
      reqValid    = '0;
      reqIsWrite  = '0;
      reqAddr     = '0;
      reqData     = '0;
      memReqReady = 1'b1;
      sendResp(1'b0, '0, '0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Reset state, including reqAck staying low while a request is pending
   // during reset.
   task automatic test_reset();
      tick();
      rst         = 1'b1;
      reqValid    = 3'b111;
      reqIsWrite  = '0;
      reqAddr     = '0;
      reqData     = '0;
      memReqReady = 1'b1;
      sendResp(1'b0, '0, '0);
      tick();
      tick();
      #1;
      vectors++;
      if (reqAck !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL reset_reqAck: got %b expected %b", reqAck, 3'b000);
      end
      vectors++;
      if ({memReqValid, memReqIsWrite, busy, protocolError} !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: got %b expected %b",
                  {memReqValid, memReqIsWrite, busy, protocolError}, 4'b0000);
      end
      vectors++;
      if ({respValid, memReqTag} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_resp_tag: got %b expected %b", {respValid, memReqTag}, 5'b0);
      end
      reqValid = '0;
      rst      = 1'b0;
   endtask

   // One read from requester 1, answered on tag 0.
   task automatic test_single_read();
      logic [LINE_WIDTH-1:0] line;
      line = {8{32'hC0DE_0001}};
      doReset();
      tick();
      applyStimulus(1, 1'b1, 1'b0, 32'h0000_1000, '0);
      #1;
      vectors++;
      if (reqAck !== 3'b010) begin
         miscompares++;
         $display("[TB] FAIL single_ack: got %b expected %b", reqAck, 3'b010);
      end
      tick();
      applyStimulus(1, 1'b0, 1'b0, '0, '0);
      #1;
      vectors++;
      if (memReqValid !== 1'b1 || memReqIsWrite !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL single_slot: got valid=%b write=%b expected valid=1 write=0",
                  memReqValid, memReqIsWrite);
      end
      vectors++;
      if (memReqAddr !== 32'h0000_1000 || memReqTag !== 2'd0) begin
         miscompares++;
         $display("[TB] FAIL single_addr_tag: got %h/%0d expected 00001000/0", memReqAddr, memReqTag);
      end
      vectors++;
      if (reqAck !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL single_no_reack: got %b expected %b", reqAck, 3'b000);
      end
      tick();
      sendResp(1'b1, 2'd0, line);
      #1;
      vectors++;
      if (memReqValid !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL single_after_hs: got valid=%b busy=%b expected valid=0 busy=1",
                  memReqValid, busy);
      end
      tick();
      sendResp(1'b0, '0, '0);
      #1;
      vectors++;
      if (respValid !== 3'b010 || respData !== line) begin
         miscompares++;
         $display("[TB] FAIL single_resp: got %b/%h expected %b/%h", respValid, respData, 3'b010, line);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL single_busy_low: got %b expected 0", busy);
      end
      tick();
      #1;
      vectors++;
      if (respValid !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL single_resp_pulse: got %b expected %b", respValid, 3'b000);
      end
   endtask

   // All three read at once from rrPtr=0, then requesters 0 and 2 again.
   task automatic test_round_robin();
      logic [REQ_NUM-1:0] expAck [3];
      logic [REQ_NUM-1:0] expResp [3];
      expAck  = '{3'b001, 3'b010, 3'b100};
      expResp = '{3'b001, 3'b010, 3'b100};
      doReset();
      tick();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(i, 1'b1, 1'b0, 32'h0000_A000 + 32'(i * 'h40), '0);
      end
      for (int k = 0; k < 3; k++) begin
         if (k > 0) tick();
         #1;
         vectors++;
         if (reqAck !== expAck[k]) begin
            miscompares++;
            $display("[TB] FAIL rr_ack%0d: got %b expected %b", k, reqAck, expAck[k]);
         end
         tick();
         applyStimulus(k, 1'b0, 1'b0, '0, '0);
         #1;
         vectors++;
         if (memReqAddr !== 32'h0000_A000 + 32'(k * 'h40) || memReqTag !== 2'(k) || reqAck !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL rr_slot%0d: got addr=%h tag=%0d ack=%b expected addr=%h tag=%0d ack=000",
                     k, memReqAddr, memReqTag, reqAck, 32'h0000_A000 + 32'(k * 'h40), k);
         end
      end
      // Drain tags 0..2 back to back.
      for (int j = 0; j < 3; j++) begin
         tick();
         sendResp(1'b1, 2'(j), {8{32'(j + 'h50)}});
         #1;
         if (j > 0) begin
            vectors++;
            if (respValid !== expResp[j-1]) begin
               miscompares++;
               $display("[TB] FAIL rr_resp%0d: got %b expected %b", j - 1, respValid, expResp[j-1]);
            end
         end
      end
      tick();
      sendResp(1'b0, '0, '0);
      #1;
      vectors++;
      if (respValid !== 3'b100 || respData !== {8{32'h52}}) begin
         miscompares++;
         $display("[TB] FAIL rr_resp2: got %b/%h expected 100/%h", respValid, respData, {8{32'h52}});
      end
      // rrPtr is back at 0: requester 0 first, then 2.
      tick();
      applyStimulus(0, 1'b1, 1'b0, 32'h0000_B000, '0);
      applyStimulus(2, 1'b1, 1'b0, 32'h0000_B080, '0);
      #1;
      vectors++;
      if (reqAck !== 3'b001) begin
         miscompares++;
         $display("[TB] FAIL rr2_ack0: got %b expected %b", reqAck, 3'b001);
      end
      tick();
      applyStimulus(0, 1'b0, 1'b0, '0, '0);
      #1;
      vectors++;
      if (memReqTag !== 2'd0 || memReqAddr !== 32'h0000_B000) begin
         miscompares++;
         $display("[TB] FAIL rr2_slot0: got %h/%0d expected 0000b000/0", memReqAddr, memReqTag);
      end
      tick();
      #1;
      vectors++;
      if (reqAck !== 3'b100) begin
         miscompares++;
         $display("[TB] FAIL rr2_ack2: got %b expected %b", reqAck, 3'b100);
      end
      tick();
      applyStimulus(2, 1'b0, 1'b0, '0, '0);
      #1;
      vectors++;
      if (memReqTag !== 2'd1 || memReqAddr !== 32'h0000_B080) begin
         miscompares++;
         $display("[TB] FAIL rr2_slot2: got %h/%0d expected 0000b080/1", memReqAddr, memReqTag);
      end
   endtask

   // Memory holds ready low for 5 cycles while another request waits.
   task automatic test_backpressure();
      logic [LINE_WIDTH-1:0] wline;
      wline = {8{32'hFACE_0002}};
      doReset();
      tick();
      memReqReady = 1'b0;
      applyStimulus(2, 1'b1, 1'b1, 32'h0000_2000, wline);
      #1;
      vectors++;
      if (reqAck !== 3'b100) begin
         miscompares++;
         $display("[TB] FAIL bp_ack: got %b expected %b", reqAck, 3'b100);
      end
      tick();
      applyStimulus(2, 1'b0, 1'b0, '0, '0);
      applyStimulus(0, 1'b1, 1'b0, 32'h0000_3000, '0);
      #1;
      for (int c = 0; c < 5; c++) begin
         vectors++;
         if (memReqValid !== 1'b1 || memReqIsWrite !== 1'b1 || memReqAddr !== 32'h0000_2000 ||
             memReqData !== wline || memReqTag !== 2'd0 || reqAck !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL bp_hold%0d: got v=%b w=%b a=%h t=%0d ack=%b expected v=1 w=1 a=00002000 t=0 ack=000",
                     c, memReqValid, memReqIsWrite, memReqAddr, memReqTag, reqAck);
         end
         tick();
         #1;
      end
      memReqReady = 1'b1;
      #1;
      vectors++;
      if (memReqValid !== 1'b1 || reqAck !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL bp_ready_cycle: got v=%b ack=%b expected v=1 ack=000", memReqValid, reqAck);
      end
      tick();
      #1;
      vectors++;
      if (memReqValid !== 1'b0 || reqAck !== 3'b001) begin
         miscompares++;
         $display("[TB] FAIL bp_idle: got v=%b ack=%b expected v=0 ack=001", memReqValid, reqAck);
      end
      tick();
      applyStimulus(0, 1'b0, 1'b0, '0, '0);
      #1;
      vectors++;
      if (memReqValid !== 1'b1 || memReqAddr !== 32'h0000_3000 || memReqTag !== 2'd0) begin
         miscompares++;
         $display("[TB] FAIL bp_next: got v=%b a=%h t=%0d expected v=1 a=00003000 t=0",
                  memReqValid, memReqAddr, memReqTag);
      end
   endtask

   // Full table blocks a read; a write still wins; a free unblocks the read.
   task automatic test_full_table();
      int reqOrder [4];
      reqOrder = '{1, 2, 1, 0};
      doReset();
      for (int k = 0; k < 4; k++) begin
         tick();
         applyStimulus(reqOrder[k], 1'b1, 1'b0, 32'h0000_4000 + 32'(k * 'h40), '0);
         #1;
         vectors++;
         if (reqAck !== (3'b001 << reqOrder[k])) begin
            miscompares++;
            $display("[TB] FAIL full_fill_ack%0d: got %b expected %b", k, reqAck, 3'b001 << reqOrder[k]);
         end
         tick();
         applyStimulus(reqOrder[k], 1'b0, 1'b0, '0, '0);
         #1;
         vectors++;
         if (memReqTag !== 2'(k)) begin
            miscompares++;
            $display("[TB] FAIL full_fill_tag%0d: got %0d expected %0d", k, memReqTag, k);
         end
      end
      // rrPtr=1 now, so requester 1 would be first if it were eligible.
      tick();
      applyStimulus(1, 1'b1, 1'b0, 32'h0000_5000, '0);
      applyStimulus(2, 1'b1, 1'b1, 32'h0000_6000, {8{32'h6666_6666}});
      #1;
      vectors++;
      if (reqAck !== 3'b100) begin
         miscompares++;
         $display("[TB] FAIL full_write_wins: got %b expected %b", reqAck, 3'b100);
      end
      tick();
      applyStimulus(2, 1'b0, 1'b0, '0, '0);
      #1;
      vectors++;
      if (memReqIsWrite !== 1'b1 || memReqTag !== 2'd0 || memReqAddr !== 32'h0000_6000) begin
         miscompares++;
         $display("[TB] FAIL full_write_slot: got w=%b t=%0d a=%h expected w=1 t=0 a=00006000",
                  memReqIsWrite, memReqTag, memReqAddr);
      end
      tick();
      sendResp(1'b1, 2'd2, {8{32'h2222_2222}});
      #1;
      vectors++;
      if (reqAck !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL full_read_blocked: got %b expected %b", reqAck, 3'b000);
      end
      tick();
      sendResp(1'b0, '0, '0);
      #1;
      vectors++;
      if (respValid !== 3'b010 || reqAck !== 3'b010) begin
         miscompares++;
         $display("[TB] FAIL full_free_grant: got resp=%b ack=%b expected resp=010 ack=010",
                  respValid, reqAck);
      end
      tick();
      applyStimulus(1, 1'b0, 1'b0, '0, '0);
      #1;
      vectors++;
      if (memReqTag !== 2'd2 || memReqIsWrite !== 1'b0 || memReqAddr !== 32'h0000_5000) begin
         miscompares++;
         $display("[TB] FAIL full_reuse_tag: got t=%0d w=%b a=%h expected t=2 w=0 a=00005000",
                  memReqTag, memReqIsWrite, memReqAddr);
      end
   endtask

   // Tags 0..3 owned by requesters 0,1,2,0 answered in order 3,1,0,2.
   task automatic test_out_of_order();
      int                 reqOrder [4];
      int                 tagOrder [4];
      logic [REQ_NUM-1:0] expResp  [4];
      reqOrder = '{0, 1, 2, 0};
      tagOrder = '{3, 1, 0, 2};
      expResp  = '{3'b001, 3'b010, 3'b001, 3'b100};
      doReset();
      for (int k = 0; k < 4; k++) begin
         tick();
         applyStimulus(reqOrder[k], 1'b1, 1'b0, 32'h0000_7000 + 32'(k * 'h40), '0);
         tick();
         applyStimulus(reqOrder[k], 1'b0, 1'b0, '0, '0);
         #1;
         vectors++;
         if (memReqTag !== 2'(k)) begin
            miscompares++;
            $display("[TB] FAIL ooo_tag%0d: got %0d expected %0d", k, memReqTag, k);
         end
      end
      for (int j = 0; j < 4; j++) begin
         tick();
         sendResp(1'b1, 2'(tagOrder[j]), {8{32'(tagOrder[j] + 'h90)}});
         #1;
         if (j > 0) begin
            vectors++;
            if (respValid !== expResp[j-1] || respData !== {8{32'(tagOrder[j-1] + 'h90)}} || busy !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL ooo_resp%0d: got %b/%h busy=%b expected %b/%h busy=1",
                        j - 1, respValid, respData[31:0], busy, expResp[j-1], 32'(tagOrder[j-1] + 'h90));
            end
         end
      end
      tick();
      sendResp(1'b0, '0, '0);
      #1;
      vectors++;
      if (respValid !== 3'b100 || respData !== {8{32'h92}} || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ooo_last: got %b/%h busy=%b expected 100/00000092 busy=0",
                  respValid, respData[31:0], busy);
      end
   endtask

   // Bogus tag on an empty table, then reset while in ISSUE.
   task automatic test_error_and_reset();
      doReset();
      tick();
      sendResp(1'b1, 2'd3, {8{32'hBAD0_BAD0}});
      tick();
      sendResp(1'b0, '0, '0);
      #1;
      vectors++;
      if (respValid !== 3'b000 || protocolError !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL err_flag: got resp=%b err=%b expected resp=000 err=1", respValid, protocolError);
      end
      tick();
      tick();
      #1;
      vectors++;
      if (protocolError !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL err_sticky: got %b expected 1", protocolError);
      end
      tick();
      memReqReady = 1'b0;
      applyStimulus(1, 1'b1, 1'b0, 32'h0000_8000, '0);
      #1;
      vectors++;
      if (reqAck !== 3'b010) begin
         miscompares++;
         $display("[TB] FAIL err_ack: got %b expected %b", reqAck, 3'b010);
      end
      tick();
      applyStimulus(1, 1'b0, 1'b0, '0, '0);
      #1;
      vectors++;
      if (memReqValid !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL err_issue: got v=%b busy=%b expected v=1 busy=1", memReqValid, busy);
      end
      rst = 1'b1;
      tick();
      #1;
      vectors++;
      if ({memReqValid, memReqIsWrite, busy, protocolError, reqAck, respValid, memReqTag} !== 12'b0 ||
          memReqAddr !== '0 || respData !== '0) begin
         miscompares++;
         $display("[TB] FAIL err_midreset: got v=%b busy=%b err=%b ack=%b resp=%b tag=%0d addr=%h expected all 0",
                  memReqValid, busy, protocolError, reqAck, respValid, memReqTag, memReqAddr);
      end
      rst         = 1'b0;
      memReqReady = 1'b1;
   endtask

   initial begin
      rst         = 1'b1;
      reqValid    = '0;
      reqIsWrite  = '0;
      reqAddr     = '0;
      reqData     = '0;
      memReqReady = 1'b1;
      memRespValid = 1'b0;
      memRespTag  = '0;
      memRespData = '0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_backpressure();
      test_full_table();
      test_out_of_order();
      test_error_and_reset();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
